// File: rtl/comm_activity_monitor.sv
// ---------------------------------------------------------------------------
// comm_activity_monitor
//
// Purpose:
//   Watches the raw intercepted bus lines and produces the comm_active
//   indication that drives the I/O handler's activity LED. It also takes the
//   handler's mode request and applies it to the MITM datapath only while the
//   bus has been quiet long enough, so a mode never changes mid-transfer.
//
// Ports:
//   sys_clk       in   1           system clock, all logic on rising edge
//   rst           in   1           asynchronous, active-high reset
//   bus_lines     in   NUM_LINES   raw asynchronous bus lines
//   mode_request  in   MODE_WIDTH  requested mode (I/O handler mode_select)
//   comm_active   out  1           bus activity indication, registered
//   mode_active   out  MODE_WIDTH  mode applied to MITM core, registered
//   mode_pending  out  1           mode_request != mode_active (combinational)
// ---------------------------------------------------------------------------
module comm_activity_monitor #(
  parameter int NUM_LINES   = 4,
  parameter int MODE_WIDTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 1200,
  parameter int IDLE_CYCLES = 12000
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic [NUM_LINES-1:0]  bus_lines,
  input  logic [MODE_WIDTH-1:0] mode_request,
  output logic                  comm_active,
  output logic [MODE_WIDTH-1:0] mode_active,
  output logic                  mode_pending
);

  localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int IDLE_W  = $clog2(IDLE_CYCLES + 1);
  localparam int PRIME_W = $clog2(SYNC_STAGES + 1);

  localparam logic [HOLD_W-1:0]  HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_ZERO   = HOLD_W'(0);
  localparam logic [IDLE_W-1:0]  IDLE_MAX    = IDLE_W'(IDLE_CYCLES);
  localparam logic [IDLE_W-1:0]  IDLE_ZERO   = IDLE_W'(0);
  localparam logic [IDLE_W-1:0]  IDLE_ONE    = IDLE_W'(1);
  localparam logic [PRIME_W-1:0] PRIME_LAST  = PRIME_W'(SYNC_STAGES);
  localparam logic [PRIME_W-1:0] PRIME_ONE   = PRIME_W'(1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Index 0 is the first flop behind the pin; the last index feeds edge detection.
  logic [SYNC_STAGES-1:0][NUM_LINES-1:0] sync_chain;
  logic [NUM_LINES-1:0]                  synced;
  logic [NUM_LINES-1:0]                  prev;
  logic [PRIME_W-1:0]                    prime_cnt;
  logic                                  primed;
  logic                                  bus_edge;
  logic                                  quiet;
  state_t                                state;
  state_t                                state_next;
  logic [HOLD_W-1:0]                     hold_cnt;
  logic [HOLD_W-1:0]                     hold_next;
  logic [IDLE_W-1:0]                     idle_cnt;

  assign synced = sync_chain[SYNC_STAGES-1];

  // Metastability synchronizer per line plus the previous-sample register.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sync_chain <= '{default: '0};
      prev       <= {NUM_LINES{1'b0}};
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], bus_lines};
      prev       <= synced;
    end
  end

  // Priming: the chain and prev start from zero, so compare only once both hold real
  // bus samples; otherwise a bus idling high would look like an edge after reset.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      prime_cnt <= PRIME_W'(0);
      primed    <= 1'b0;
    end else if (!primed) begin
      if (prime_cnt == PRIME_LAST) begin
        primed <= 1'b1;
      end else begin
        prime_cnt <= prime_cnt + PRIME_ONE;
      end
    end
  end

  assign bus_edge = primed && (synced != prev);

  // Activity FSM state and hold counter registers.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      hold_cnt    <= HOLD_ZERO;
      comm_active <= 1'b0;
    end else begin
      state       <= state_next;
      hold_cnt    <= hold_next;
      comm_active <= (state_next == ACTIVE);
    end
  end

  // Activity FSM next state: any edge (re)loads the hold; expiry returns to IDLE.
  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    case (state)
      IDLE: begin
        if (bus_edge) begin
          state_next = ACTIVE;
          hold_next  = HOLD_RELOAD;
        end else begin
          state_next = IDLE;
          hold_next  = hold_cnt;
        end
      end
      ACTIVE: begin
        if (bus_edge) begin
          state_next = ACTIVE;
          hold_next  = HOLD_RELOAD;
        end else if (hold_cnt == HOLD_ZERO) begin
          state_next = IDLE;
          hold_next  = HOLD_ZERO;
        end else begin
          state_next = ACTIVE;
          hold_next  = hold_cnt - HOLD_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        hold_next  = HOLD_ZERO;
      end
    endcase
  end

  // Quiet-time counter; starts saturated so the bus is treated as quiet after reset.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= IDLE_MAX;
    end else if (bus_edge) begin
      idle_cnt <= IDLE_ZERO;
    end else if (idle_cnt != IDLE_MAX) begin
      idle_cnt <= idle_cnt + IDLE_ONE;
    end
  end

  // An edge in the same cycle as saturation blocks the update.
  assign quiet        = (idle_cnt == IDLE_MAX) && !bus_edge;
  assign mode_pending = (mode_request != mode_active);

  // Mode gating: only the request present when the bus is quiet is applied.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      mode_active <= {MODE_WIDTH{1'b0}};
    end else if (mode_pending && quiet) begin
      mode_active <= mode_request;
    end
  end

endmodule
